// File: rtl/shift_unit_iterative_if.sv
// Start/busy/done handshake bundle between the EX-stage control and the iterative shifter.
interface shift_unit_iterative_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [1:0]            ShiftType;
    logic [DATA_WIDTH-1:0] DataInput;
    logic [DATA_WIDTH-1:0] ShamtInput;
    logic                  Busy;
    logic                  Done;
    logic [DATA_WIDTH-1:0] ShiftResult;

    modport master (
        output Start,
        output ShiftType,
        output DataInput,
        output ShamtInput,
        input  Busy,
        input  Done,
        input  ShiftResult
    );

    modport slave (
        input  Start,
        input  ShiftType,
        input  DataInput,
        input  ShamtInput,
        output Busy,
        output Done,
        output ShiftResult
    );
endinterface

// File: rtl/shift_unit_iterative.sv
// Iterative SLL/SRL/SRA shifter, one bit per cycle; define SHIFT_UNIT_RADIX4_EN to
// step by four bits while at least four remain.
module shift_unit_iterative #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input logic                   clk,
    input logic                   reset,
    shift_unit_iterative_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_RSV = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

    localparam logic [SHAMT_WIDTH-1:0] CNT_ZERO = {SHAMT_WIDTH{1'b0}};
    localparam logic [SHAMT_WIDTH-1:0] CNT_ONE  = SHAMT_WIDTH'(1);
`ifdef SHIFT_UNIT_RADIX4_EN
    localparam logic [SHAMT_WIDTH-1:0] CNT_FOUR = SHAMT_WIDTH'(4);
`endif

    state_t                  state_r,  state_s;
    logic [SHAMT_WIDTH-1:0]  count_r,  count_s;
    logic [DATA_WIDTH-1:0]   work_r,   work_s;
    logic [1:0]              kind_r,   kind_s;
    logic [DATA_WIDTH-1:0]   result_r, result_s;
    logic                    busy_r,   busy_s;
    logic                    done_r,   done_s;

    // Upper shamt bits arrive from the zero-extend stage but carry no meaning here.
    logic unused_shamt_high_s;
    assign unused_shamt_high_s = ^bus.ShamtInput[DATA_WIDTH-1:SHAMT_WIDTH];

    function automatic logic [DATA_WIDTH-1:0] shift_by_one(
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            kind
    );
        logic [DATA_WIDTH-1:0] res;
        case (kind)
            SH_SLL:  res = {data[DATA_WIDTH-2:0], 1'b0};
            SH_SRL:  res = {1'b0, data[DATA_WIDTH-1:1]};
            SH_SRA:  res = {data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
            default: res = data;
        endcase
        return res;
    endfunction

`ifdef SHIFT_UNIT_RADIX4_EN
    function automatic logic [DATA_WIDTH-1:0] shift_by_four(
        input logic [DATA_WIDTH-1:0] data,
        input logic [1:0]            kind
    );
        logic [DATA_WIDTH-1:0] res;
        case (kind)
            SH_SLL:  res = {data[DATA_WIDTH-5:0], 4'b0000};
            SH_SRL:  res = {4'b0000, data[DATA_WIDTH-1:4]};
            SH_SRA:  res = {{4{data[DATA_WIDTH-1]}}, data[DATA_WIDTH-1:4]};
            default: res = data;
        endcase
        return res;
    endfunction
`endif

    // Next-state, datapath and next-output logic; Busy/Done are computed one edge early
    // so that both outputs come straight from flops.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        work_s   = work_r;
        kind_s   = kind_r;
        result_s = result_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    work_s = bus.DataInput;
                    kind_s = bus.ShiftType;
                    if (bus.ShiftType == SH_RSV) begin
                        count_s = CNT_ZERO;
                    end else begin
                        count_s = bus.ShamtInput[SHAMT_WIDTH-1:0];
                    end
                    if (count_s == CNT_ZERO) begin
                        state_s  = ST_DONE;
                        result_s = bus.DataInput;
                        done_s   = 1'b1;
                    end else begin
                        state_s = ST_SHIFT;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
`ifdef SHIFT_UNIT_RADIX4_EN
                if (count_r >= CNT_FOUR) begin
                    work_s  = shift_by_four(work_r, kind_r);
                    count_s = count_r - CNT_FOUR;
                end else begin
                    work_s  = shift_by_one(work_r, kind_r);
                    count_s = count_r - CNT_ONE;
                end
`else
                work_s  = shift_by_one(work_r, kind_r);
                count_s = count_r - CNT_ONE;
`endif
                if (count_s == CNT_ZERO) begin
                    state_s  = ST_DONE;
                    result_s = work_s;
                    done_s   = 1'b1;
                end else begin
                    state_s = ST_SHIFT;
                    busy_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            count_r  <= CNT_ZERO;
            work_r   <= {DATA_WIDTH{1'b0}};
            kind_r   <= SH_SLL;
            result_r <= {DATA_WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            work_r   <= work_s;
            kind_r   <= kind_s;
            result_r <= result_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign bus.Busy        = busy_r;
    assign bus.Done        = done_r;
    assign bus.ShiftResult = result_r;

endmodule

// File: tb/tb_shift_unit_iterative.sv
// Self-checking bench for shift_unit_iterative: directed table, random ops against an
// arithmetic reference, and hand-written multi-cycle sequences.
module tb_shift_unit_iterative;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    shift_unit_iterative_if #(.DATA_WIDTH(32)) bus ();

    shift_unit_iterative #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ty;
        logic [31:0] data;
        logic [31:0] shamt;
        logic [31:0] exp_res;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] ty, input logic [31:0] s);
        int n;
        n = (ty == 2'b10) ? 0 : int'(s[4:0]);
`ifdef SHIFT_UNIT_RADIX4_EN
        return n / 4 + n % 4 + 1;
`else
        return n + 1;
`endif
    endfunction

    function automatic logic [31:0] exp_res(input logic [1:0] ty, input logic [31:0] d,
                                            input logic [31:0] s);
        int n;
        n = int'(s % 32);
        case (ty)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b11:   return 32'($signed(d) >>> n);
            default: return d;
        endcase
    endfunction

    // Issues one op in the cycle after the call, scrambles inputs and pulses Start while
    // the op is in flight, and reports result, Start-to-Done latency and Busy cycles.
    task automatic run_op(input logic [1:0] ty, input logic [31:0] d, input logic [31:0] s,
                          output logic [31:0] res, output int lat, output int busy_n);
        @(negedge clk);
        bus.Start      = 1'b1;
        bus.ShiftType  = ty;
        bus.DataInput  = d;
        bus.ShamtInput = s;
        lat    = 0;
        busy_n = 0;
        res    = 32'h0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (bus.Busy) busy_n++;
            if (bus.Done) begin
                lat = c;
                res = bus.ShiftResult;
                bus.Start = 1'b0;
                break;
            end
            bus.Start      = bus.Busy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.DataInput  = $urandom;
            bus.ShamtInput = $urandom;
            bus.ShiftType  = 2'($urandom_range(0, 3));
        end
        bus.Start = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [1:0] ty, input logic [31:0] d,
                            input logic [31:0] s, input logic [31:0] want);
        logic [31:0] res;
        int          lat;
        int          busy_n;
        run_op(ty, d, s, res, lat, busy_n);
        chk({name, " result"}, res, want);
        chk({name, " latency"}, 32'(lat), 32'(exp_lat(ty, s)));
        chk({name, " busy"}, 32'(busy_n), 32'(exp_lat(ty, s) - 1));
    endtask

    initial begin
        vec_t        vecs[$];
        logic [1:0]  ty;
        logic [31:0] d;
        logic [31:0] s;
        int          done_cnt;
        int          done_at;
        logic [31:0] held;
        int          rst_cyc;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.Start      = 1'b0;
        bus.ShiftType  = 2'b00;
        bus.DataInput  = 32'h0;
        bus.ShamtInput = 32'h0;

        vecs.push_back('{2'b00, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, "sll31"});
        vecs.push_back('{2'b11, 32'h8000_00F0, 32'h0000_0004, 32'hF800_000F, "sra4"});
        vecs.push_back('{2'b01, 32'h8000_00F0, 32'h0000_0004, 32'h0800_000F, "srl4"});
        vecs.push_back('{2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, "sll0"});
        vecs.push_back('{2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, "sra0"});
        vecs.push_back('{2'b10, 32'h1234_5678, 32'h0000_0011, 32'h1234_5678, "reserved"});
        vecs.push_back('{2'b00, 32'h0000_0003, 32'h0000_0025, 32'h0000_0060, "shamt_hi"});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, "sra31"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFE1, 32'h7FFF_FFFF, "srl1_hi"});

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset Busy", 32'(bus.Busy), 32'h0);
        chk("reset Done", 32'(bus.Done), 32'h0);
        chk("reset ShiftResult", bus.ShiftResult, 32'h0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            check_op(vecs[i].name, vecs[i].ty, vecs[i].data, vecs[i].shamt, vecs[i].exp_res);
        end

        for (int i = 0; i < 40; i++) begin
            ty = 2'($urandom_range(0, 3));
            d  = $urandom;
            s  = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 31));
            check_op("random", ty, d, s, exp_res(ty, d, s));
        end

        // Second Start three cycles into an SLL by 10 must be ignored
        @(negedge clk);
        bus.Start = 1'b1; bus.ShiftType = 2'b00;
        bus.DataInput = 32'h0000_0001; bus.ShamtInput = 32'd10;
        done_cnt = 0; done_at = 0; held = 32'h0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.Done) begin
                done_cnt++;
                done_at = c;
                held = bus.ShiftResult;
            end
            bus.Start = (c == 3);
            bus.ShiftType = 2'b01; bus.DataInput = 32'h0000_00FF; bus.ShamtInput = 32'd2;
        end
        chk("restart done count", 32'(done_cnt), 32'd1);
        chk("restart done cycle", 32'(done_at), 32'(exp_lat(2'b00, 32'd10)));
        chk("restart result", held, 32'h0000_0400);
        chk("restart result held", bus.ShiftResult, 32'h0000_0400);

        // Reset in the middle of an SRL by 20 aborts it without a Done pulse
`ifdef SHIFT_UNIT_RADIX4_EN
        rst_cyc = 3;
`else
        rst_cyc = 7;
`endif
        @(negedge clk);
        bus.Start = 1'b1; bus.ShiftType = 2'b01;
        bus.DataInput = 32'hFFFF_FFFF; bus.ShamtInput = 32'd20;
        done_cnt = 0;
        for (int c = 1; c <= rst_cyc; c++) begin
            @(negedge clk);
            bus.Start = 1'b0;
            if (bus.Done) done_cnt++;
        end
        chk("pre-reset busy", 32'(bus.Busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort Busy", 32'(bus.Busy), 32'h0);
        chk("abort Done", 32'(bus.Done), 32'h0);
        chk("abort ShiftResult", bus.ShiftResult, 32'h0);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) done_cnt++;
        end
        chk("abort no activity", 32'(done_cnt), 32'h0);
        check_op("after_reset", 2'b00, 32'h0000_0003, 32'h0000_0025, 32'h0000_0060);

        // Start together with reset: reset wins
        @(negedge clk);
        bus.Start = 1'b1; bus.ShiftType = 2'b00;
        bus.DataInput = 32'h0000_0001; bus.ShamtInput = 32'd3;
        reset = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) done_cnt++;
        end
        chk("start+reset ignored", 32'(done_cnt), 32'h0);
        chk("start+reset result", bus.ShiftResult, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit_iterative.md
Name: shift_unit_iterative

Overview:
- Multi-cycle shifter in the EX stage; it takes the zero-extended 32-bit shamt operand produced by the unsigned-extend stage.
- Performs SLL/SRL/SRA by one bit per cycle (four with the optional feature) under a start/busy/done handshake.
- Busy drives the pipeline stall logic so ID/EX holds while the shift completes.
- Replaces the combinational barrel shift path to shorten the EX critical path.

Parameters:
- DATA_WIDTH, 32, width of data operand and result
- SHAMT_WIDTH, 5, number of low ShamtInput bits used as the shift count

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  request pulse; accepted only in IDLE
- ShiftType  input  2  00 SLL, 01 SRL, 11 SRA, 10 reserved
- DataInput  input  DATA_WIDTH  value to shift (rt)
- ShamtInput  input  DATA_WIDTH  zero-extended shift amount; only bits [SHAMT_WIDTH-1:0] used
- Busy  output  1  high while a shift is in progress (SHIFT state)
- Done  output  1  one-cycle pulse, result valid
- ShiftResult  output  DATA_WIDTH  shifted value, held until next accepted Start

Behaviour:
- Reset values: state IDLE, Busy=0, Done=0, ShiftResult=0, internal count=0. Reset takes effect on the clock edge where reset=1 and aborts any in-flight shift with no Done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, Start=1:
  - Latch DataInput into the working register, ShiftType into the type register, ShamtInput[4:0] into Count.
  - Count==0: go to DONE.
  - Otherwise: go to SHIFT.
- IDLE, Start=0: hold; ShiftResult keeps its last value.
- SHIFT, per cycle, shift the working register by 1:
  - SLL: shift left, LSB filled with 0.
  - SRL: shift right, MSB filled with 0.
  - SRA: shift right, MSB replicated.
  - Count decrements by 1; when Count reaches 0, go to DONE.
- DONE:
  - ShiftResult is loaded from the working register on the DONE entry edge.
  - Done=1 for exactly one cycle, then return to IDLE.
- Latency from the Start edge to Done high is N+1 cycles for shamt N (N=0 gives 1, N=31 gives 32). Busy is high for N cycles.
- Start while Busy or in DONE is ignored: no restart, no queueing. Start in the cycle after Done is accepted normally.
- ShiftType=10 (reserved): treated as pass-through. Count is forced to 0, ShiftResult=DataInput, Done after 1 cycle.
- ShamtInput bits above SHAMT_WIDTH-1 are ignored (e.g. 0x25 shifts by 5).
- Inputs are sampled only on the accepted Start edge; later changes have no effect.
- Start and reset high together: reset wins.

Optional Feature:
- Macro: SHIFT_UNIT_RADIX4_EN.
- Defined: in SHIFT, when Count>=4 the working register shifts by 4 and Count decrements by 4; otherwise by 1. Latency for shamt N is floor(N/4)+(N mod 4)+1 (N=31 gives 11).
- Undefined: strictly one bit per cycle as above.
- Fill and sign rules are identical in both modes, and results are bit-identical.

Test Plan:
- Start, SLL, DataInput=0x0000_0001, ShamtInput=0x0000_001F -> Busy high 31 cycles; Done on the 32nd cycle after Start; ShiftResult=0x8000_0000.
- Start, SRA, DataInput=0x8000_00F0, ShamtInput=4 -> Done 5 cycles after Start; ShiftResult=0xF800_000F. Same with SRL -> 0x0800_000F.
- Start, ShamtInput=0 (any type), DataInput=0xDEAD_BEEF -> Busy never high; Done next cycle; ShiftResult=0xDEAD_BEEF.
- Second Start pulse 3 cycles into an SLL by 10 of 0x1 -> ignored; single Done at cycle 11 with 0x0000_0400; ShiftResult stays stable afterwards.
- reset asserted mid-shift (SRL 0xFFFF_FFFF by 20, cycle 7) -> next edge Busy=0, Done=0, ShiftResult=0; no Done pulse; new Start afterwards behaves normally.
- ShamtInput=0x0000_0025 SLL 0x3 -> shifts by 5, result 0x0000_0060. With SHIFT_UNIT_RADIX4_EN defined, Done arrives 3 cycles after Start instead of 6.
